// File: rtl/cs_accum.sv
// cs_accum: carry-save accumulator and two-cycle resolver for MAC adder-tree outputs.
// Beats of redundant (sum, carry) vectors fold into a carry-save running total with
// no carry propagation. The last beat of a packet triggers a split low/high
// carry-propagate add, and the binary total is offered on a valid/ready port.
// Optional feature macro: CS_ACCUM_SAT_EN (saturate out_data and flag out_ovf when the
// total does not fit in ACC_W bits). When undefined, out_data wraps and out_ovf is 0.
module cs_accum #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int IW = ACC_W + 4;
    localparam int L  = IW / 2;
    localparam int H  = IW - L;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        RES_LO = 2'd1,
        RES_HI = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0] acc_s;
    logic [IW-1:0] acc_c;
    logic [L-1:0]  lo_sum;
    logic          lo_cy;
    logic          accept;

    logic [IW-1:0] ext_sum;
    logic [IW-1:0] ext_carry;
    logic [IW-1:0] r1_s;
    logic [IW-1:0] r1_c;
    logic [IW-1:0] r2_s;
    logic [IW-1:0] r2_c;
    logic [L:0]    lo_add;

`ifdef CS_ACCUM_SAT_EN
    logic [H-1:0]  hi_add;
    logic [IW-1:0] total;
`else
    logic [ACC_W-L-1:0] hi_add;
    logic [ACC_W-1:0]   total;
`endif

    assign accept = in_valid && in_ready;

    // State register; reset drops any partial packet or pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accumulate until the last beat, resolve in two steps, hold until consumed
    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && in_last) state_next = RES_LO;
            RES_LO:  state_next = RES_HI;
            RES_HI:  state_next = OUT;
            OUT:     if (out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Handshake outputs are pure functions of state so they never glitch with inputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC:     in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // 4:2 compression as two full-adder rows; the carry out of the top bit falls off the shift
    always_comb begin
        ext_sum   = IW'(in_sum);
        ext_carry = IW'({in_carry, 1'b0});
        r1_s      = acc_s ^ acc_c ^ ext_sum;
        r1_c      = ((acc_s & acc_c) | (acc_s & ext_sum) | (acc_c & ext_sum)) << 1;
        r2_s      = r1_s ^ r1_c ^ ext_carry;
        r2_c      = ((r1_s & r1_c) | (r1_s & ext_carry) | (r1_c & ext_carry)) << 1;
    end

    // Split carry-propagate add: low half feeds a registered carry into the high half
    always_comb begin
        lo_add = {1'b0, acc_s[L-1:0]} + {1'b0, acc_c[L-1:0]};
`ifdef CS_ACCUM_SAT_EN
        hi_add = acc_s[IW-1:L] + acc_c[IW-1:L] + H'(lo_cy);
`else
        hi_add = acc_s[ACC_W-1:L] + acc_c[ACC_W-1:L] + (ACC_W-L)'(lo_cy);
`endif
        total  = {hi_add, lo_sum};
    end

    // Running carry-save total, cleared once its value has been resolved
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_s <= '0;
            acc_c <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc_s <= r2_s;
                        acc_c <= r2_c;
                    end
                end
                RES_HI: begin
                    acc_s <= '0;
                    acc_c <= '0;
                end
                default: begin
                    acc_s <= acc_s;
                    acc_c <= acc_c;
                end
            endcase
        end
    end

    // Low half of the resolve, captured between the two add cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_sum <= '0;
            lo_cy  <= 1'b0;
        end else if (state == RES_LO) begin
            lo_sum <= lo_add[L-1:0];
            lo_cy  <= lo_add[L];
        end
    end

`ifdef CS_ACCUM_SAT_EN
    // Result register: saturate when any guard bit of the total is set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (state == RES_HI) begin
            if (|total[IW-1:ACC_W]) begin
                out_data <= '1;
                out_ovf  <= 1'b1;
            end else begin
                out_data <= total[ACC_W-1:0];
                out_ovf  <= 1'b0;
            end
        end
    end
`else
    // Result register: the total wraps modulo 2^ACC_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
        end else if (state == RES_HI) begin
            out_data <= total;
        end
    end

    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cs_accum.sv
// tb_cs_accum: directed self-checking bench for cs_accum.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_cs_accum;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sum;
    logic [7:0]  in_carry;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    cs_accum #(.WIDTH(8), .ACC_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive an n-beat packet of identical beats, one beat per cycle, last flag on the final one
    task automatic send_packet(input logic [7:0] s, input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sum   = s;
            in_carry = c;
            in_last  = (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sum   = 8'h00;
        in_carry = 8'h00;
    endtask

    // Wait a bounded number of cycles for out_valid
    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Consume the pending result with a one-cycle out_ready pulse
    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = 8'h00;
        in_carry  = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_out_data got %h want 0000", out_data);
        end
        checks++;
        if (out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_ovf got %b want 0", out_ovf);
        end
    endtask

    task automatic test_single_beat();
        in_valid = 1'b1;
        in_sum   = 8'h05;
        in_carry = 8'h03;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_res_lo got rdy=%b vld=%b want rdy=0 vld=0", in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_res_hi got rdy=%b vld=%b want rdy=0 vld=0", in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_latency got vld=%b want 1", out_valid);
        end
        checks++;
        if (out_data !== 16'd11 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_data got %0d ovf=%b want 11 ovf=0", out_data, out_ovf);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_after_hs got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bs [5];
        logic [7:0]  bc [5];
        logic        bl [5];
        logic [15:0] exp_res [2];
        int idx  = 0;
        int nres = 0;
        int low  = 0;
        int cyc  = 0;
        bit acc;
        bs = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
        bc = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
        bl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_res = '{16'd3, 16'd4};
        out_ready = 1'b1;
        while (nres < 2 && cyc < 60) begin
            if (idx < 5) begin
                in_valid = 1'b1;
                in_sum   = bs[idx];
                in_carry = bc[idx];
                in_last  = bl[idx];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (!in_ready) low++;
            if (out_valid) begin
                checks++;
                if (out_data !== exp_res[nres]) begin
                    errors++;
                    $display("[TB] FAIL b2b_data%0d got %0d want %0d", nres, out_data, exp_res[nres]);
                end
                nres++;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nres != 2) begin
            errors++;
            $display("[TB] FAIL b2b_results got %0d want 2", nres);
        end
        checks++;
        if (low != 6) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready_low_cycles got %0d want 6", low);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] exp_data;
        logic        exp_ovf;
`ifdef CS_ACCUM_SAT_EN
        exp_data = 16'hFFFF;
        exp_ovf  = 1'b1;
`else
        exp_data = 16'hFD00;
        exp_ovf  = 1'b0;
`endif
        send_packet(8'hFF, 8'hFF, 256);
        wait_out(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ovf_timeout got no out_valid want out_valid");
        end
        checks++;
        if (out_data !== exp_data || out_ovf !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL ovf_data got %h ovf=%b want %h ovf=%b", out_data, out_ovf, exp_data, exp_ovf);
        end
        consume();
    endtask

    task automatic test_backpressure();
        bit ok;
        send_packet(8'd7, 8'd0, 1);
        wait_out(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bp_timeout got no out_valid want out_valid");
        end
        in_valid = 1'b1;
        in_sum   = 8'd9;
        in_carry = 8'd0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_data !== 16'd7 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got data=%0d rdy=%b vld=%b want data=7 rdy=0 vld=1",
                         i, out_data, in_ready, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_out(ok);
        checks++;
        if (!ok || out_data !== 16'd9) begin
            errors++;
            $display("[TB] FAIL bp_next_packet got ok=%b data=%0d want ok=1 data=9", ok, out_data);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_packet(8'h50, 8'h20, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset got vld=%b data=%h rdy=%b want vld=0 data=0000 rdy=1",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_packet(8'd2, 8'd0, 1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== 16'd2) begin
            errors++;
            $display("[TB] FAIL midreset_next got ok=%b data=%0d want ok=1 data=2", ok, out_data);
        end
        consume();
    endtask

    task automatic test_zero();
        bit ok;
        send_packet(8'd0, 8'd0, 1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== 16'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_packet got ok=%b data=%0d ovf=%b want ok=1 data=0 ovf=0",
                     ok, out_data, out_ovf);
        end
        consume();
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
